// File: rtl/mantissa_reciprocal_seed_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fp_recip_pkg                                                 |
// | Description : Shared types and the reciprocal-seed table generator for the |
// |               mantissa reciprocal seed pipeline.                           |
// |               recip_seed() : table entry for one index and configuration   |
// |               recip_req_t  : lookup request {index, tag}, sized for the    |
// |                              default 8-bit index / 4-bit tag build         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package fp_recip_pkg;

  localparam int unsigned REQ_IDX_WIDTH = 8;
  localparam int unsigned REQ_TAG_WIDTH = 4;

  typedef struct packed {
    logic [REQ_IDX_WIDTH-1:0] index;
    logic [REQ_TAG_WIDTH-1:0] tag;
  } recip_req_t;

  // Reciprocal of the interval midpoint 1 + (2i+1)/2**(idx_width+1), in
  // 0.out_width fixed point. Both numerator and divisor carry the same
  // 2**(idx_width+1) scale, so the midpoint stays an exact odd integer.
  function automatic logic [63:0] recip_seed(input int unsigned idx,
                                             input int unsigned idx_width,
                                             input int unsigned out_width,
                                             input bit          round_near);
    logic [63:0] w_den;
    logic [63:0] w_num;
    w_den = (64'd1 << (idx_width + 1)) + 64'(2 * idx) + 64'd1;
    w_num = 64'd1 << (out_width + idx_width + 1);
    if (round_near) begin
      return (w_num + (w_den >> 1)) / w_den;
    end
    return w_num / w_den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mantissa_reciprocal_seed_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : mantissa_reciprocal_seed_pipe_if                             |
// | Description : Request/response handshake bundle of the reciprocal seed     |
// |               pipeline.                                                    |
// |               in_valid/in_ready/in_index/in_tag     : request side         |
// |               out_valid/out_ready/out_recip/out_tag : result side          |
// |               master : requester and result consumer                       |
// |               slave  : the seed pipeline                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface mantissa_reciprocal_seed_pipe_if #(
  parameter int unsigned IDX_WIDTH = 8,
  parameter int unsigned OUT_WIDTH = 24,
  parameter int unsigned TAG_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IDX_WIDTH-1:0] in_index;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_recip;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_index, in_tag, out_ready,
    input  in_ready, out_valid, out_recip, out_tag
  );

  modport slave (
    input  in_valid, in_index, in_tag, out_ready,
    output in_ready, out_valid, out_recip, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/mantissa_reciprocal_seed_pipe_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : recip_seed_rom                                               |
// | Description : Synchronous-read reciprocal seed ROM, contents fixed at      |
// |               elaboration from fp_recip_pkg::recip_seed().                 |
// |               clk, rst : clock, synchronous active-high reset              |
// |               i_en     : load o_data from the addressed entry              |
// |               i_addr   : table index                                       |
// |               o_data   : registered table entry (zero after reset)         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module recip_seed_rom #(
  parameter int unsigned IDX_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned ROUND_NEAR = 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_en,
  input  wire logic [IDX_WIDTH-1:0] i_addr,
  output logic      [OUT_WIDTH-1:0] o_data
);
  import fp_recip_pkg::*;

  localparam int unsigned C_DEPTH = 2 ** IDX_WIDTH;

  logic [OUT_WIDTH-1:0] w_rom [C_DEPTH];

  // Every entry is below 2**OUT_WIDTH, so the narrowing cast drops only zeros.
  for (genvar gi = 0; gi < C_DEPTH; gi++) begin : g_rom
    assign w_rom[gi] = OUT_WIDTH'(recip_seed(gi, IDX_WIDTH, OUT_WIDTH, ROUND_NEAR != 0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data <= '0;
    end else if (i_en) begin
      o_data <= w_rom[i_addr];
    end
  end
endmodule
`default_nettype wire

// File: rtl/mantissa_reciprocal_seed_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mantissa_reciprocal_seed_pipe                                |
// | Description : Two-stage pipelined mantissa reciprocal seed lookup with     |
// |               valid/ready flow control and a tag carried per lookup.       |
// |               S1 holds index+tag, S2 holds the ROM read+tag and drives     |
// |               the outputs. Two-cycle latency, one result per cycle.        |
// |               clk, rst : clock, synchronous active-high reset              |
// |               bus      : slave side of mantissa_reciprocal_seed_pipe_if    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mantissa_reciprocal_seed_pipe #(
  parameter int unsigned IDX_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned ROUND_NEAR = 1
) (
  input wire logic                     clk,
  input wire logic                     rst,
  mantissa_reciprocal_seed_pipe_if.slave bus
);
  import fp_recip_pkg::*;

  logic                 r_s1_valid;
  logic [IDX_WIDTH-1:0] r_s1_index;
  logic [TAG_WIDTH-1:0] r_s1_tag;
  logic                 r_s2_valid;
  logic [TAG_WIDTH-1:0] r_s2_tag;
  logic                 w_s2_load;
  logic                 w_s1_load;
  logic                 w_accept;
  logic                 w_rom_en;
  logic [OUT_WIDTH-1:0] w_rom_data;

  // Each stage advances when it is empty or its successor is taking its
  // contents, so a full pipeline still moves every cycle while out_ready=1.
  assign w_s2_load = !r_s2_valid | bus.out_ready;
  assign w_s1_load = !r_s1_valid | w_s2_load;
  assign w_accept  = bus.in_valid & bus.in_ready;
  // Only real lookups are copied into S2, so outputs keep their last value
  // while the pipeline drains idle cycles.
  assign w_rom_en  = w_s2_load & r_s1_valid;

  assign bus.in_ready = !rst & w_s1_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_index <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_tag   <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= w_accept;
      end
      if (w_accept) begin
        r_s1_index <= bus.in_index;
        r_s1_tag   <= bus.in_tag;
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_rom_en) begin
        r_s2_tag <= r_s1_tag;
      end
    end
  end

  recip_seed_rom #(
    .IDX_WIDTH  (IDX_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .ROUND_NEAR (ROUND_NEAR)
  ) u_s2_rom (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_rom_en),
    .i_addr (r_s1_index),
    .o_data (w_rom_data)
  );

  assign bus.out_valid = r_s2_valid;
  assign bus.out_recip = w_rom_data;
  assign bus.out_tag   = r_s2_tag;
endmodule
`default_nettype wire
